etm_div: RTL
============

Name: etm_div

Overview:
- Sequential error-tolerant unsigned divider for the approx_arith HWPE library. It is the inverse-direction companion to the error-tolerant multiplier.
- The high quotient part is computed exactly by an iterative restoring divider. The low K quotient bits are approximated by OR-saturation, mirroring the multiplier's OR-propagated low half.
- Operands enter and results leave over valid/ready streams. It sits between HWPE streamer and datapath stages.

Parameters:
- N, 8, operand and quotient width in bits (N >= 2).
- K, 3, number of approximated low quotient bits (0 <= K < N); K=0 gives exact division.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands.
- a_i  in  N  unsigned dividend.
- b_i  in  N  unsigned divisor.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- q_o  out  N  approximate quotient.
- dz_o  out  1  divide-by-zero flag, qualified by out_valid_o.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: FSM goes to IDLE. in_ready_o=1, out_valid_o=0, q_o=0, dz_o=0. All internal registers clear.
- Reset asserted mid-operation aborts the operation immediately; the result is lost and no output is produced.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On in_valid_i: register a_i and b_i.
  - If b_i==0: go to DONE with q=all ones, dz=1.
  - Otherwise: clear remainder r (N bits), set iteration index j=N-1, go to RUN.
- RUN: one quotient bit per cycle, for j = N-1 down to K.
  - Compute t = {r[N-2:0], a[j]} (r shifted left, a[j] appended).
  - If t >= b: r <= t-b and q[j] <= 1. Otherwise: r <= t and q[j] <= 0.
  - After the j==K iteration, go to DONE.
  - On that transition, the fill bit f = (next r != 0) | (|a[K-1:0]). Set q[K-1:0] to all ones if f, else to all zeros. When K=0 there are no fill bits.
  - Net result: q[N-1:K] = floor((a>>K)/b) exactly. Low bits are all ones if any remainder information exists, else zeros.
- DONE:
  - out_valid_o=1; q_o and dz_o hold stable.
  - On out_ready_i: return to IDLE.
  - in_ready_o=0 in DONE, so an operand is never accepted in the same cycle a result retires.
- in_ready_o=0 in RUN and DONE; in_valid_i is ignored there.
- Latency:
  - b!=0: accept edge, then N-K RUN cycles, then out_valid_o rises. That is N-K+1 cycles from the accept edge.
  - b==0: out_valid_o rises 1 cycle after accept.
- Throughput: one result per N-K+2 cycles when out_ready_i is held high.
- Output stability: q_o and dz_o change only on entry to DONE or on reset. Backpressure of any length in DONE holds all outputs constant.
- dz_o=0 for every nonzero divisor.
- Width rules: all arithmetic is unsigned. t is N bits; r < b is always guaranteed, so no overflow occurs.

Test Plan:
- N=8,K=3: a=200, b=7 -> out_valid_o after 6 cycles, q_o=31 (q_hi=3, remainder 4 -> fill 111), dz_o=0.
- N=8,K=3: a=64, b=8 -> q_o=8, fill 000 (remainder 0, low dividend bits 0).
- N=8,K=3: a=65, b=8 -> q_o=15 (remainder 0 but a[2:0]!=0 -> fill 111).
- N=8,K=3: a=57, b=0 -> q_o=255, dz_o=1, out_valid_o one cycle after accept.
- N=8,K=0: a=200, b=7 -> q_o=28 exact, latency 9 cycles. Then hold out_ready_i=0 for 5 cycles -> q_o stable and in_ready_o=0 throughout.
- Reset mid-RUN (assert rst_i 2 cycles after accept) -> outputs return to reset values immediately and no result is emitted. The next operand pair after reset computes correctly; back-to-back random stimulus matches the reference model.

Source files
------------

// File: rtl/etm_div_if.sv
// Operand/result stream bundle for the error-tolerant divider.
// The stream signals keep their _i/_o names as seen from the divider side.
interface etm_div_if #(
    parameter int N = 8
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [N-1:0] q_o;
    logic         dz_o;

    modport slave (
        input  in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, q_o, dz_o
    );

    modport master (
        output in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, q_o, dz_o
    );
endinterface

// File: rtl/etm_div.sv
// Sequential error-tolerant unsigned divider: the quotient bits above K come from an
// exact restoring divider, and the K low bits are OR-saturated from the leftover remainder.
module etm_div #(
    parameter int N = 8,
    parameter int K = 3
) (
    input logic       clk_i,
    input logic       rst_i,
    etm_div_if.slave  bus
);
    localparam int JW = (N > 2) ? $clog2(N) : 1;
    localparam logic [N-1:0] LOW_MASK = {N{1'b1}} >> (N - K);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] a_q, b_q, r, r_nxt, qw, qw_nxt, q_out;
    logic [N:0]   t, diff;
    logic [JW-1:0] j;
    logic         dz, ge, last;

    // Low quotient bits become all ones if any remainder or discarded dividend bit survives.
    function automatic logic [N-1:0] or_saturate(input logic [N-1:0] q,
                                                 input logic [N-1:0] rem,
                                                 input logic [N-1:0] dividend);
        logic fill;
        fill = (|rem) | (|(dividend & LOW_MASK));
        return (q & ~LOW_MASK) | (fill ? LOW_MASK : '0);
    endfunction

    // r < b always holds here, so a borrow out of the top bit is the "t < b" test.
    always_comb begin
        t      = {r, a_q[j]};
        diff   = t - {1'b0, b_q};
        ge     = ~diff[N];
        r_nxt  = ge ? diff[N-1:0] : t[N-1:0];
        qw_nxt = qw;
        qw_nxt[j] = ge;
        last   = (j == JW'(K));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid_i) state_nxt = (bus.b_i == '0) ? DONE : RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            r     <= '0;
            qw    <= '0;
            j     <= '0;
            q_out <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        a_q <= bus.a_i;
                        b_q <= bus.b_i;
                        r   <= '0;
                        qw  <= '0;
                        j   <= JW'(N - 1);
                        if (bus.b_i == '0) begin
                            q_out <= '1;
                            dz    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r  <= r_nxt;
                    qw <= qw_nxt;
                    j  <= j - 1'b1;
                    if (last) begin
                        q_out <= or_saturate(qw_nxt, r_nxt, a_q);
                        dz    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // q_out/dz are only written on entry to DONE, so backpressure never disturbs them.
    assign bus.in_ready_o  = (state == IDLE);
    assign bus.out_valid_o = (state == DONE);
    assign bus.q_o         = q_out;
    assign bus.dz_o        = dz;
endmodule
